// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and an IDLE/RUN/HALTED
// control FSM. Memory is external and returns the word at outAddr before the next rising edge.
module instruction_fetch #(
    parameter int unsigned MEM_DEPTH = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        enable,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_in,
    output logic [31:0] outAddr,
    output logic [31:0] outPCNext,
    output logic [31:0] outInstruction,
    output logic        outValid,
    output logic        outHalted,
    output logic [31:0] outCycles
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    localparam logic [31:0] Depth    = 32'(MEM_DEPTH);
    localparam logic [31:0] LastAddr = Depth - 32'd1;

    localparam logic [1:0] SrcSeq    = 2'b00;
    localparam logic [1:0] SrcBranch = 2'b01;
    localparam logic [1:0] SrcJump   = 2'b10;
    localparam logic [1:0] SrcJr     = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] cycles_q, cycles_d;

    logic [31:0] pc_inc;
    logic [31:0] redirect_raw;
    logic [31:0] redirect_pc;
    logic        advance;
    logic        halt_capture;

    // PC is always kept below Depth, so a compare replaces a full modulo on the hot path.
    assign pc_inc = (pc_q == LastAddr) ? 32'd0 : pc_q + 32'd1;

    always_comb begin
        redirect_raw = pc_inc;
        unique case (pc_src)
            SrcSeq:    redirect_raw = pc_inc;
            SrcBranch: redirect_raw = branch_target;
            SrcJump:   redirect_raw = jump_target;
            SrcJr:     redirect_raw = jr_target;
        endcase
    end

    assign redirect_pc = redirect_raw % Depth;

    // Flush overrides stall, so a flushing cycle always advances.
    assign advance      = (state_q == StRun) && enable && (!stall || flush);
    assign halt_capture = advance && !flush && (instr_in == HALT_WORD);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        cycles_d  = cycles_q;

        if (advance) begin
            cycles_d = cycles_q + 32'd1;
        end

        if (enable) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (flush) begin
                        pc_d    = redirect_pc;
                        instr_d = 32'd0;
                        valid_d = 1'b0;
                    end else if (!stall) begin
                        instr_d   = instr_in;
                        pc_next_d = pc_inc;
                        valid_d   = 1'b1;
                        // The halt word is latched, but PC stays parked on its address.
                        if (halt_capture) begin
                            state_d = StHalted;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
                StHalted: begin
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= 32'd0;
            pc_next_q <= 32'd0;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
            cycles_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            cycles_q  <= cycles_d;
        end
    end

    assign outAddr        = pc_q;
    assign outPCNext      = pc_next_q;
    assign outInstruction = instr_q;
    assign outValid       = valid_q;
    assign outHalted      = (state_q == StHalted);
    assign outCycles      = cycles_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 32-word memory model read on the falling edge.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        enable;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] instr_in;
    logic [31:0] outAddr;
    logic [31:0] outPCNext;
    logic [31:0] outInstruction;
    logic        outValid;
    logic        outHalted;
    logic [31:0] outCycles;

    logic [31:0] mem [32];
    int          tests;
    int          fails;
    logic [31:0] exp_cycles;

    instruction_fetch #(
        .MEM_DEPTH(32),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .enable        (enable),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .instr_in      (instr_in),
        .outAddr       (outAddr),
        .outPCNext     (outPCNext),
        .outInstruction(outInstruction),
        .outValid      (outValid),
        .outHalted     (outHalted),
        .outCycles     (outCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) instr_in = mem[outAddr[4:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; enable = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_src = 2'b00; branch_target = 0; jump_target = 0; jr_target = 0;
        tick();
        rst = 1'b0;
        exp_cycles = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; flush = 1'b1; start = 1'b1; stall = 1'b0;
        pc_src = 2'b10; jump_target = 32'd9;
        tick();
        tests++; if (outAddr !== 32'd0) begin
            fails++; $display("FAIL reset_addr: got %0d want 0", outAddr); end
        tests++; if (outPCNext !== 32'd0) begin
            fails++; $display("FAIL reset_pcnext: got %0d want 0", outPCNext); end
        tests++; if (outInstruction !== 32'd0) begin
            fails++; $display("FAIL reset_instr: got %h want 0", outInstruction); end
        tests++; if (outValid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b want 0", outValid); end
        tests++; if (outHalted !== 1'b0) begin
            fails++; $display("FAIL reset_halted: got %b want 0", outHalted); end
        tests++; if (outCycles !== 32'd0) begin
            fails++; $display("FAIL reset_cycles: got %0d want 0", outCycles); end
        // IDLE ignores flush; start with enable=0 must not leave IDLE.
        rst = 1'b0; start = 1'b0;
        tick(); tick();
        tests++; if (outAddr !== 32'd0 || outValid !== 1'b0) begin
            fails++; $display("FAIL idle_flush: got addr %0d valid %b want 0 0", outAddr, outValid);
        end
        flush = 1'b0; enable = 1'b0; start = 1'b1;
        tick();
        enable = 1'b1; start = 1'b0;
        tick(); tick();
        tests++; if (outCycles !== 32'd0 || outAddr !== 32'd0) begin
            fails++;
            $display("FAIL idle_start_gated: got cyc %0d addr %0d want 0 0", outCycles, outAddr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++; if (outAddr !== 32'(k)) begin
                fails++; $display("FAIL seq_addr_pre[%0d]: got %0d want %0d", k, outAddr, k); end
            tick(); exp_cycles++;
            tests++; if (outInstruction !== mem[k]) begin
                fails++; $display("FAIL seq_instr[%0d]: got %h want %h", k, outInstruction, mem[k]);
            end
            tests++; if (outPCNext !== 32'(k + 1) || outValid !== 1'b1) begin
                fails++; $display("FAIL seq_pcnext[%0d]: got %0d/%b want %0d/1",
                                  k, outPCNext, outValid, k + 1);
            end
        end
        tests++; if (outCycles !== 32'd4) begin
            fails++; $display("FAIL seq_cycles: got %0d want 4", outCycles); end
    endtask

    task automatic test_stall();
        tick(); exp_cycles++;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (outAddr !== 32'd5 || outInstruction !== mem[4] || outCycles !== exp_cycles)
            begin
                fails++; $display("FAIL stall_hold[%0d]: got addr %0d instr %h cyc %0d want 5 %h %0d",
                                  k, outAddr, outInstruction, outCycles, mem[4], exp_cycles);
            end
        end
        stall = 1'b0;
        tick(); exp_cycles++;
        tests++; if (outInstruction !== mem[5] || outAddr !== 32'd6 || outCycles !== 32'd6) begin
            fails++; $display("FAIL stall_release: got instr %h addr %0d cyc %0d want %h 6 6",
                              outInstruction, outAddr, outCycles, mem[5]);
        end
    endtask

    task automatic test_flush();
        repeat (11) begin tick(); exp_cycles++; end
        tests++; if (outAddr !== 32'd17) begin
            fails++; $display("FAIL flush_pre_addr: got %0d want 17", outAddr); end
        flush = 1'b1; pc_src = 2'b10; jump_target = 32'd11; stall = 1'b1;
        tick(); exp_cycles++;
        tests++; if (outAddr !== 32'd11 || outInstruction !== 32'd0 || outValid !== 1'b0) begin
            fails++; $display("FAIL flush_jump: got addr %0d instr %h valid %b want 11 0 0",
                              outAddr, outInstruction, outValid);
        end
        tests++; if (outCycles !== 32'd18) begin
            fails++; $display("FAIL flush_cycles: got %0d want 18", outCycles); end
        flush = 1'b0; stall = 1'b0;
        tick(); exp_cycles++;
        tests++; if (outInstruction !== mem[11] || outValid !== 1'b1 || outAddr !== 32'd12) begin
            fails++; $display("FAIL flush_refetch: got instr %h valid %b addr %0d want %h 1 12",
                              outInstruction, outValid, outAddr, mem[11]);
        end
        flush = 1'b1; pc_src = 2'b00;
        tick(); exp_cycles++;
        tests++; if (outAddr !== 32'd13 || outValid !== 1'b0) begin
            fails++; $display("FAIL flush_seq: got addr %0d valid %b want 13 0", outAddr, outValid);
        end
        pc_src = 2'b11; jr_target = 32'd40;
        tick(); exp_cycles++;
        tests++; if (outAddr !== 32'd8) begin
            fails++; $display("FAIL flush_jr_mod: got %0d want 8", outAddr); end
        flush = 1'b0;
    endtask

    task automatic test_halt_with_flush();
        mem[8] = 32'hFFFF_FFFF;
        flush = 1'b1; pc_src = 2'b01; branch_target = 32'd4;
        tick(); exp_cycles++;
        tests++; if (outAddr !== 32'd4 || outHalted !== 1'b0 || outValid !== 1'b0) begin
            fails++; $display("FAIL halt_flush: got addr %0d halted %b valid %b want 4 0 0",
                              outAddr, outHalted, outValid);
        end
        mem[8] = 32'hA000_0008;
        flush = 1'b0;
        tick(); exp_cycles++;
        tests++; if (outAddr !== 32'd5 || outInstruction !== mem[4] || outHalted !== 1'b0) begin
            fails++; $display("FAIL halt_flush_run: got addr %0d instr %h halted %b want 5 %h 0",
                              outAddr, outInstruction, outHalted, mem[4]);
        end
        tests++; if (outCycles !== exp_cycles) begin
            fails++; $display("FAIL halt_flush_cycles: got %0d want %0d", outCycles, exp_cycles);
        end
    endtask

    task automatic test_wrap();
        mem[31] = 32'h1234_5678;
        flush = 1'b1; pc_src = 2'b10; jump_target = 32'd31;
        tick(); exp_cycles++;
        flush = 1'b0;
        tests++; if (outAddr !== 32'd31) begin
            fails++; $display("FAIL wrap_pre_addr: got %0d want 31", outAddr); end
        tick(); exp_cycles++;
        tests++; if (outAddr !== 32'd0 || outPCNext !== 32'd0 || outInstruction !== 32'h1234_5678)
        begin
            fails++; $display("FAIL wrap_seq: got addr %0d pcnext %0d instr %h want 0 0 12345678",
                              outAddr, outPCNext, outInstruction);
        end
        flush = 1'b1; pc_src = 2'b01; branch_target = 32'd33;
        tick(); exp_cycles++;
        tests++; if (outAddr !== 32'd1) begin
            fails++; $display("FAIL wrap_branch: got %0d want 1", outAddr); end
        flush = 1'b0;
        mem[31] = 32'hFFFF_FFFF;
    endtask

    task automatic test_halt();
        flush = 1'b1; pc_src = 2'b10; jump_target = 32'd29;
        tick(); exp_cycles++;
        flush = 1'b0;
        repeat (3) begin tick(); exp_cycles++; end
        tests++; if (outHalted !== 1'b1 || outAddr !== 32'd31) begin
            fails++; $display("FAIL halt_enter: got halted %b addr %0d want 1 31", outHalted, outAddr);
        end
        tests++; if (outInstruction !== 32'hFFFF_FFFF || outValid !== 1'b1) begin
            fails++; $display("FAIL halt_capture: got instr %h valid %b want ffffffff 1",
                              outInstruction, outValid);
        end
        tests++; if (outCycles !== exp_cycles) begin
            fails++; $display("FAIL halt_cycles: got %0d want %0d", outCycles, exp_cycles); end
        tick();
        tests++; if (outInstruction !== 32'd0 || outValid !== 1'b0 || outAddr !== 32'd31) begin
            fails++; $display("FAIL halt_nop: got instr %h valid %b addr %0d want 0 0 31",
                              outInstruction, outValid, outAddr);
        end
        start = 1'b1; flush = 1'b1; pc_src = 2'b10; jump_target = 32'd3;
        tick(); tick();
        tests++; if (outAddr !== 32'd31 || outHalted !== 1'b1 || outCycles !== exp_cycles) begin
            fails++; $display("FAIL halt_ignore: got addr %0d halted %b cyc %0d want 31 1 %0d",
                              outAddr, outHalted, outCycles, exp_cycles);
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (outHalted !== 1'b0 || outAddr !== 32'd0 || outCycles !== 32'd0) begin
            fails++; $display("FAIL halt_reset: got halted %b addr %0d cyc %0d want 0 0 0",
                              outHalted, outAddr, outCycles);
        end
        tick();
        tests++; if (outAddr !== 32'd0 || outValid !== 1'b0) begin
            fails++; $display("FAIL halt_reset_idle: got addr %0d valid %b want 0 0", outAddr, outValid);
        end
        flush = 1'b0;
    endtask

    task automatic test_enable_and_midrun_reset();
        do_reset();
        enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        enable = 1'b0; flush = 1'b1; pc_src = 2'b10; jump_target = 32'd20; start = 1'b1;
        tick(); tick();
        tests++; if (outAddr !== 32'd2 || outCycles !== 32'd2) begin
            fails++; $display("FAIL enable_freeze: got addr %0d cyc %0d want 2 2", outAddr, outCycles);
        end
        tests++; if (outInstruction !== mem[1] || outValid !== 1'b1) begin
            fails++; $display("FAIL enable_freeze_ifid: got %h/%b want %h/1",
                              outInstruction, outValid, mem[1]);
        end
        enable = 1'b1; flush = 1'b0; start = 1'b0;
        tick();
        tests++; if (outAddr !== 32'd3 || outCycles !== 32'd3) begin
            fails++; $display("FAIL enable_resume: got addr %0d cyc %0d want 3 3", outAddr, outCycles);
        end
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tests++; if (outAddr !== 32'd0 || outValid !== 1'b0 || outCycles !== 32'd0) begin
            fails++; $display("FAIL midrun_reset: got addr %0d valid %b cyc %0d want 0 0 0",
                              outAddr, outValid, outCycles);
        end
        flush = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cycles = 0;
        instr_in = 32'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[31] = 32'hFFFF_FFFF;
        rst = 1'b1; start = 1'b0; enable = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_src = 2'b00; branch_target = 0; jump_target = 0; jr_target = 0;

        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_halt_with_flush();
        test_wrap();
        test_halt();
        test_enable_and_midrun_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
